// File: rtl/clk_pkg.sv
// Shared types and constants for the forwarded-clock transmitter.
package clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam int DIV_W_DEF  = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int CLK_SYS_HZ = 200_000_000;

    // Forwarded clock frequency for a given half-period divisor.
    function automatic int f_out_hz(input int div);
        return CLK_SYS_HZ / (2 * (div + 1));
    endfunction

endpackage

// File: rtl/diff_obuf.sv
// Differential output buffer wrapper: vendor OBUFDS in synthesis,
// a behavioural complementary pair otherwise. Both legs come from one input.
module diff_obuf #(
    parameter IOSTD = "DEFAULT"
) (
    input  logic out_q,
    output logic clkoutP,
    output logic clkoutN
);

`ifdef SYNTHESIS
    OBUFDS #(
        .IOSTANDARD(IOSTD)
    ) u_obufds (
        .I (out_q),
        .O (clkoutP),
        .OB(clkoutN)
    );
`else
    // The I/O standard has no meaning for the behavioural pair.
    logic unused_iostd;
    assign unused_iostd = ^{1'b0, IOSTD};

    assign clkoutP = out_q;
    assign clkoutN = ~out_q;
`endif

endmodule

// File: rtl/diff_clk_fwd.sv
// Differential clock forwarding transmitter. Divides clk200MHz by a
// programmable half period, starts and stops without runt pulses, and
// drives the result off-chip as a P/N pair.
module diff_clk_fwd
    import clk_pkg::*;
#(
    parameter int DIV_W      = DIV_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter     DIFF_IOSTD = "DEFAULT"
) (
    input  logic             clk200MHz,
    input  logic             rst,
    input  logic             en_req,
    input  logic [DIV_W-1:0] div,
    output logic             en_ack,
    output logic             running,
    output logic             rise_stb,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             clkoutP,
    output logic             clkoutN
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             out_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic             hit;

    // End of the current half period.
    assign hit = (cnt == div_q);

    // Control FSM, half-period counter and the single clock register.
    // Stopping only ever ends a high phase early never; it lets the high
    // phase finish and then parks low, so no pulse is shorter than div_q+1.
    always_ff @(posedge clk200MHz) begin
        if (rst) begin
            state    <= IDLE;
            out_q    <= 1'b0;
            en_ack   <= 1'b0;
            running  <= 1'b0;
            rise_stb <= 1'b0;
            edge_cnt <= '0;
            cnt      <= '0;
            div_q    <= '0;
        end else begin
            rise_stb <= 1'b0;
            case (state)
                IDLE: begin
                    out_q <= 1'b0;
                    if (en_req) begin
                        div_q    <= div;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        running  <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    en_ack <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    if (!en_req && !out_q) begin
                        // Low phase: just extend it and park.
                        cnt     <= '0;
                        en_ack  <= 1'b0;
                        running <= 1'b0;
                        state   <= IDLE;
                    end else if (hit) begin
                        cnt <= '0;
                        if (!en_req) begin
                            // High phase ends exactly now: fall and park.
                            out_q   <= 1'b0;
                            en_ack  <= 1'b0;
                            running <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            out_q <= ~out_q;
                            if (!out_q) begin
                                rise_stb <= 1'b1;
                                edge_cnt <= edge_cnt + CNT_ONE;
                            end
                        end
                    end else begin
                        cnt <= cnt + DIV_ONE;
                        if (!en_req) begin
                            en_ack <= 1'b0;
                            state  <= STOPPING;
                        end
                    end
                end
                STOPPING: begin
                    if (hit) begin
                        out_q   <= 1'b0;
                        cnt     <= '0;
                        running <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + DIV_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    diff_obuf #(
        .IOSTD(DIFF_IOSTD)
    ) u_obuf (
        .out_q  (out_q),
        .clkoutP(clkoutP),
        .clkoutN(clkoutN)
    );

endmodule

// File: tb/tb_diff_clk_fwd.sv
// Bench for diff_clk_fwd: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a timeline model of the output clock.
module tb_diff_clk_fwd;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam logic [CW+4:0] RESET_VEC = {5'b00001, {CW{1'b0}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          en_req;
    logic [DW-1:0] div;
    logic          en_ack;
    logic          running;
    logic          rise_stb;
    logic [CW-1:0] edge_cnt;
    logic          clkoutP;
    logic          clkoutN;
    logic [CW+4:0] obs;

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    // Model: mode 0 off, 1 load, 2 run, 3 stopping; m_t counts cycles since run began.
    int m_mode = 0;
    int m_t    = 0;
    int m_d    = 0;
    int m_edges = 0;

    diff_clk_fwd #(
        .DIV_W     (DW),
        .CNT_W     (CW),
        .DIFF_IOSTD("LVDS_25")
    ) dut (
        .clk200MHz(clk),
        .rst      (rst),
        .en_req   (en_req),
        .div      (div),
        .en_ack   (en_ack),
        .running  (running),
        .rise_stb (rise_stb),
        .edge_cnt (edge_cnt),
        .clkoutP  (clkoutP),
        .clkoutN  (clkoutN)
    );

    always #5 clk = ~clk;

    assign obs = {running, en_ack, rise_stb, clkoutP, clkoutN, edge_cnt};

    // Clock level in the model: odd-numbered half periods are high.
    function automatic bit m_out();
        return (m_mode == 2 || m_mode == 3) && (((m_t / (m_d + 1)) % 2) == 1);
    endfunction

    function automatic logic [CW+4:0] exp_vec();
        bit o;
        bit r;
        logic [CW-1:0] e;
        o = m_out();
        r = (m_mode == 2) && o && ((m_t % (m_d + 1)) == 0);
        e = CW'(m_edges);
        return {m_mode != 0, m_mode == 2, r, o, ~o, e};
    endfunction

    task automatic mdl_step();
        if (rst) begin
            m_mode = 0; m_t = 0; m_d = 0; m_edges = 0;
        end else begin
            case (m_mode)
                0: if (en_req) begin
                    m_mode = 1; m_d = int'(div); m_edges = 0;
                end
                1: begin
                    m_mode = 2; m_t = 0;
                end
                2: if (!en_req && !m_out()) begin
                    m_mode = 0;
                end else begin
                    m_t++;
                    if (!en_req) m_mode = ((m_t % (m_d + 1)) == 0) ? 0 : 3;
                    else m_edges = ((m_t / (m_d + 1)) + 1) / 2;
                end
                default: begin
                    m_t++;
                    if ((m_t % (m_d + 1)) == 0) m_mode = 0;
                end
            endcase
        end
    endtask

    // Advance one clock, update the model with the inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        mdl_step();
        started = 1'b1;
        #1;
    endtask

    // Differential legs must always be complementary.
    always @(negedge clk) begin
        if (started) begin
            n_chk++;
            if (clkoutN !== ~clkoutP)
                $display("FAIL legs: clkoutP=%b clkoutN=%b want complementary", clkoutP, clkoutN);
            else
                n_pass++;
        end
    end

    task automatic go_idle();
        bit done;
        done = 1'b0;
        en_req = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL idle_model: dut=%h model=%h", obs, exp_vec());
            else n_pass++;
            if (running === 1'b0) done = 1'b1;
        end
        n_chk++;
        if (!done) $display("FAIL idle_timeout: running=%b want 0", running);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_req = 1'b0; div = '0;
        repeat (5) begin
            step();
            n_chk++;
            if (obs !== RESET_VEC) $display("FAIL reset: dut=%h want=%h", obs, RESET_VEC);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_div0();
        en_req = 1'b1; div = 8'd0;
        step();
        n_chk++;
        if (running !== 1'b1 || en_ack !== 1'b0) $display("FAIL div0_load: running=%b en_ack=%b want 1 0", running, en_ack);
        else n_pass++;
        step();
        n_chk++;
        if (en_ack !== 1'b1 || clkoutP !== 1'b0) $display("FAIL div0_run: en_ack=%b clkoutP=%b want 1 0", en_ack, clkoutP);
        else n_pass++;
        repeat (20) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL div0_model: dut=%h model=%h", obs, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (edge_cnt !== 8'd10) $display("FAIL div0_edges: edge_cnt=%0d want 10", edge_cnt);
        else n_pass++;
    endtask

    task automatic test_div3();
        int last;
        int hi;
        int rises;
        go_idle();
        en_req = 1'b1; div = 8'd3;
        last = -1; hi = 0; rises = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == 20) div = 8'd7;
            step();
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL div3_model: dut=%h model=%h", obs, exp_vec());
            else n_pass++;
            if (rise_stb === 1'b1) begin
                rises++;
                if (last >= 0) begin
                    n_chk++;
                    if (i - last != 8) $display("FAIL div3_period: got %0d want 8", i - last);
                    else n_pass++;
                end
                last = i;
            end
            if (clkoutP === 1'b1) hi++;
            else begin
                if (hi > 0) begin
                    n_chk++;
                    if (hi != 4) $display("FAIL div3_high: got %0d want 4", hi);
                    else n_pass++;
                end
                hi = 0;
            end
        end
        n_chk++;
        if (rises != 8) $display("FAIL div3_rises: got %0d want 8", rises);
        else n_pass++;
    endtask

    task automatic wait_rise(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL %s_model: dut=%h model=%h", tag, obs, exp_vec());
            else n_pass++;
            if (rise_stb === 1'b1) got = 1'b1;
        end
        n_chk++;
        if (!got) $display("FAIL %s_rise_timeout: rise_stb=%b want 1", tag, rise_stb);
        else n_pass++;
    endtask

    task automatic test_stop_high();
        int hi;
        int rises;
        bit low;
        go_idle();
        en_req = 1'b1; div = 8'd3;
        wait_rise("stophi");
        en_req = 1'b0;
        hi = 0; low = 1'b0;
        for (int k = 0; k < 20 && !low; k++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL stophi_model: dut=%h model=%h", obs, exp_vec());
            else n_pass++;
            if (clkoutP === 1'b1) hi++;
            else low = 1'b1;
        end
        n_chk++;
        if (hi != 3 || running !== 1'b0) $display("FAIL stophi_tail: high=%0d running=%b want 3 0", hi, running);
        else n_pass++;
        rises = 0;
        repeat (20) begin
            step();
            if (rise_stb === 1'b1) rises++;
        end
        n_chk++;
        if (rises != 0) $display("FAIL stophi_norise: got %0d want 0", rises);
        else n_pass++;
    endtask

    task automatic test_stop_low();
        bit low;
        go_idle();
        en_req = 1'b1; div = 8'd3;
        wait_rise("stoplo");
        low = 1'b0;
        for (int k = 0; k < 20 && !low; k++) begin
            step();
            if (clkoutP === 1'b0) low = 1'b1;
        end
        en_req = 1'b0;
        step();
        n_chk++;
        if (running !== 1'b0 || clkoutP !== 1'b0 || en_ack !== 1'b0)
            $display("FAIL stoplo_idle: running=%b clkoutP=%b en_ack=%b want 0 0 0", running, clkoutP, en_ack);
        else n_pass++;
        repeat (3) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL stoplo_model: dut=%h model=%h", obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_rst_pulse();
        int k;
        bit got;
        go_idle();
        en_req = 1'b1; div = 8'd2;
        wait_rise("rstp");
        rst = 1'b1;
        step();
        n_chk++;
        if (obs !== RESET_VEC) $display("FAIL rstp_reset: dut=%h want=%h", obs, RESET_VEC);
        else n_pass++;
        rst = 1'b0; div = 8'd5;
        step();
        n_chk++;
        if (running !== 1'b1 || en_ack !== 1'b0 || edge_cnt !== '0)
            $display("FAIL rstp_load: running=%b en_ack=%b edge_cnt=%0d want 1 0 0", running, en_ack, edge_cnt);
        else n_pass++;
        got = 1'b0; k = 0;
        while (k < 30 && !got) begin
            step();
            k++;
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL rstp_model: dut=%h model=%h", obs, exp_vec());
            else n_pass++;
            if (rise_stb === 1'b1) got = 1'b1;
        end
        n_chk++;
        if (k != 7 || edge_cnt !== 8'd1) $display("FAIL rstp_first_rise: cycles=%0d edge_cnt=%0d want 7 1", k, edge_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int rises;
        go_idle();
        en_req = 1'b1; div = 8'd0;
        rises = 0;
        for (int k = 0; k < 700 && rises < 257; k++) begin
            step();
            n_chk++;
            if (obs !== exp_vec()) $display("FAIL wrap_model: dut=%h model=%h", obs, exp_vec());
            else n_pass++;
            if (rise_stb === 1'b1) rises++;
        end
        n_chk++;
        if (rises != 257 || edge_cnt !== 8'd1) $display("FAIL wrap: rises=%0d edge_cnt=%0d want 257 1", rises, edge_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) en_req = ~en_req;
            div = 8'($urandom_range(0, 5));
            rst = ($urandom_range(0, 299) == 0);
            step();
            n_chk++;
            if (obs !== exp_vec()) begin
                if (errs < 10) $display("FAIL random_model: cyc=%0d dut=%h model=%h", k, obs, exp_vec());
                errs++;
            end else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_req = 1'b0; div = '0;
        test_reset();
        test_div0();
        test_div3();
        test_stop_high();
        test_stop_low();
        test_rst_pulse();
        test_wrap();
        test_random();
        go_idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
